// File: rtl/seq_detector_prog_if.sv
// Serial-bit / pattern-control bundle between a bit source and seq_detector_prog.
// master drives stream and control; slave returns the match pulse and counter.
interface seq_detector_prog_if #(
  parameter int LEN   = 4,
  parameter int CNT_W = 8
);
  logic             din_valid;
  logic             din;
  logic             pat_load;
  logic [LEN-1:0]   pat_in;
  logic             overlap;
  logic             clr_count;
  logic             y;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;

  modport master (
    output din_valid, din, pat_load, pat_in, overlap, clr_count,
    input  y, match_count, count_sat
  );

  modport slave (
    input  din_valid, din, pat_load, pat_in, overlap, clr_count,
    output y, match_count, count_sat
  );
endinterface

// File: rtl/seq_detector_prog.sv
// Runtime-loadable LEN-bit serial pattern detector with saturating match counter.
// y is registered: high for the cycle after the completing bit; no backpressure.
module seq_detector_prog #(
  parameter int             LEN     = 4,
  parameter int             CNT_W   = 8,
  parameter logic [LEN-1:0] RST_PAT = LEN'(4'b1011)
) (
  input logic               clk,
  input logic               rst,
  seq_detector_prog_if.slave bus
);
  localparam int FILL_W = $clog2(LEN + 1);

  logic [LEN-1:0]   pat;
  // Only the newest LEN-1 bits can ever reach the comparison window.
  logic [LEN-2:0]   hist;
  logic [FILL_W-1:0] fill;
  logic [CNT_W-1:0] cnt;
  logic             y_q;

  logic [LEN-1:0]   win;
  logic             hit;
  logic             cnt_full;

  assign win      = {hist, bus.din};
  assign cnt_full = &cnt;
  assign hit      = bus.din_valid & ~bus.pat_load
                  & (fill >= FILL_W'(LEN - 1)) & (win == pat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat  <= RST_PAT;
      hist <= '0;
      fill <= '0;
      y_q  <= 1'b0;
      cnt  <= '0;
    end else begin
      y_q <= hit;

      if (bus.pat_load) begin
        pat  <= bus.pat_in;
        hist <= '0;
        fill <= '0;
      end else if (bus.din_valid) begin
        hist <= win[LEN-2:0];
        // Non-overlapping mode demands LEN fresh bits after every match.
        if (hit && !bus.overlap)
          fill <= '0;
        else if (fill != FILL_W'(LEN))
          fill <= fill + FILL_W'(1);
      end

      if (bus.clr_count)
        cnt <= hit ? CNT_W'(1) : '0;
      else if (hit && !cnt_full)
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.y           = y_q;
  assign bus.match_count = cnt;
  assign bus.count_sat   = cnt_full;
endmodule
